// File: rtl/l2_port_arbiter.sv
// Two-port L1 -> L2 line-transaction arbiter: round-robin grant, one request in flight, response steered to owner.
// Optional build macro L2ARB_WB_PRIO_EN: a writeline beats a competing readline regardless of rr_ptr.
module l2_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_rw,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [LINE_W-1:0] m0_req_wline,
  output logic              m0_resp_valid,
  output logic [LINE_W-1:0] m0_resp_rline,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_rw,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [LINE_W-1:0] m1_req_wline,
  output logic              m1_resp_valid,
  output logic [LINE_W-1:0] m1_resp_rline,
  output logic              l2_req_valid,
  input  logic              l2_req_ready,
  output logic              l2_req_rw,
  output logic [ADDR_W-1:0] l2_req_addr,
  output logic [LINE_W-1:0] l2_req_wline,
  input  logic              l2_resp_valid,
  input  logic [LINE_W-1:0] l2_resp_rline,
  output logic              err_unexp_resp,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RESP = 2'd2
  } state_t;

  state_t state;
  logic   rr_ptr;
  logic   owner;
  logic   grant_c;
  logic   any_valid;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready; a
  // requester holds valid and its payload stable until it sees ready.
  always_comb begin
    grant_c = rr_ptr;
    if (m0_req_valid && !m1_req_valid) begin
      grant_c = 1'b0;
    end else if (!m0_req_valid && m1_req_valid) begin
      grant_c = 1'b1;
    end
`ifdef L2ARB_WB_PRIO_EN
    else if (m0_req_valid && m1_req_valid && (m0_req_rw != m1_req_rw)) begin
      grant_c = m1_req_rw;
    end
`endif
  end

  assign any_valid     = m0_req_valid || m1_req_valid;
  assign m0_req_ready  = (state == S_IDLE) && m0_req_valid && !grant_c;
  assign m1_req_ready  = (state == S_IDLE) && m1_req_valid && grant_c;

  assign m0_resp_valid = (state == S_WAIT_RESP) && !owner && l2_resp_valid;
  assign m1_resp_valid = (state == S_WAIT_RESP) && owner && l2_resp_valid;
  assign m0_resp_rline = l2_resp_rline;
  assign m1_resp_rline = l2_resp_rline;

  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= 1'b0;
      owner        <= 1'b0;
      l2_req_valid <= 1'b0;
      l2_req_rw    <= 1'b0;
      l2_req_addr  <= '0;
      l2_req_wline <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            l2_req_valid <= 1'b1;
            l2_req_rw    <= grant_c ? m1_req_rw    : m0_req_rw;
            l2_req_addr  <= grant_c ? m1_req_addr  : m0_req_addr;
            l2_req_wline <= grant_c ? m1_req_wline : m0_req_wline;
            owner        <= grant_c;
            rr_ptr       <= ~grant_c;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (l2_req_valid && l2_req_ready) begin
            l2_req_valid <= 1'b0;
            state        <= l2_req_rw ? S_IDLE : S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (l2_resp_valid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A response is only legal while a readline is outstanding; anything else is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unexp_resp <= 1'b0;
    end else if (l2_resp_valid && (state != S_WAIT_RESP)) begin
      err_unexp_resp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: transaction-level model checked every cycle, directed scenarios, then random traffic.
module tb_l2_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk;
  logic              rst_n;
  logic              m0_req_valid, m0_req_ready, m0_req_rw, m0_resp_valid;
  logic [ADDR_W-1:0] m0_req_addr;
  logic [LINE_W-1:0] m0_req_wline, m0_resp_rline;
  logic              m1_req_valid, m1_req_ready, m1_req_rw, m1_resp_valid;
  logic [ADDR_W-1:0] m1_req_addr;
  logic [LINE_W-1:0] m1_req_wline, m1_resp_rline;
  logic              l2_req_valid, l2_req_ready, l2_req_rw;
  logic [ADDR_W-1:0] l2_req_addr;
  logic [LINE_W-1:0] l2_req_wline;
  logic              l2_resp_valid;
  logic [LINE_W-1:0] l2_resp_rline;
  logic              err_unexp_resp;
  logic [1:0]        dbg_state;

  l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_rw(m0_req_rw),
    .m0_req_addr(m0_req_addr), .m0_req_wline(m0_req_wline),
    .m0_resp_valid(m0_resp_valid), .m0_resp_rline(m0_resp_rline),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_rw(m1_req_rw),
    .m1_req_addr(m1_req_addr), .m1_req_wline(m1_req_wline),
    .m1_resp_valid(m1_resp_valid), .m1_resp_rline(m1_resp_rline),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_rw(l2_req_rw),
    .l2_req_addr(l2_req_addr), .l2_req_wline(l2_req_wline),
    .l2_resp_valid(l2_resp_valid), .l2_resp_rline(l2_resp_rline),
    .err_unexp_resp(err_unexp_resp), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // ---------------- transaction-level model ----------------
  // busy: a request was taken from an L1; sent: L2 has accepted it.
  bit                busy, sent, owner_m, pref, err_m;
  logic              rw_m;
  logic [ADDR_W-1:0] addr_m;
  logic [LINE_W-1:0] wline_m;
  logic [ADDR_W-1:0] acc_q[$];
  int                resp_cnt[2];
  logic [LINE_W-1:0] last_rline[2];

  function automatic int pick_port();
    if (m0_req_valid && !m1_req_valid) return 0;
    if (m1_req_valid && !m0_req_valid) return 1;
`ifdef L2ARB_WB_PRIO_EN
    if (m0_req_rw != m1_req_rw) return m1_req_rw ? 1 : 0;
`endif
    return int'(pref);
  endfunction

  always @(negedge clk) begin : compare
    int p;
    logic [1:0] exp_state;
    if (!rst_n) begin
      busy = 0; sent = 0; owner_m = 0; pref = 0; err_m = 0;
      rw_m = 0; addr_m = '0; wline_m = '0;
      chk("rst_l2_valid", l2_req_valid, 0);
      chk("rst_l2_rw", l2_req_rw, 0);
      chk("rst_l2_addr", l2_req_addr, 0);
      chk("rst_l2_wline", l2_req_wline, 0);
      chk("rst_err", err_unexp_resp, 0);
      chk("rst_m0_resp", m0_resp_valid, 0);
      chk("rst_m1_resp", m1_resp_valid, 0);
      chk("rst_state", dbg_state, 0);
    end else begin
      p = pick_port();
      exp_state = !busy ? 2'd0 : (!sent ? 2'd1 : 2'd2);
      chk("m0_ready", m0_req_ready, !busy && m0_req_valid && p == 0);
      chk("m1_ready", m1_req_ready, !busy && m1_req_valid && p == 1);
      chk("l2_valid", l2_req_valid, busy && !sent);
      if (busy && !sent) begin
        chk("l2_rw", l2_req_rw, rw_m);
        chk("l2_addr", l2_req_addr, addr_m);
        chk("l2_wline", l2_req_wline, wline_m);
      end
      chk("m0_resp_valid", m0_resp_valid, busy && sent && !owner_m && l2_resp_valid);
      chk("m1_resp_valid", m1_resp_valid, busy && sent && owner_m && l2_resp_valid);
      chk("m0_rline", m0_resp_rline, l2_resp_rline);
      chk("m1_rline", m1_resp_rline, l2_resp_rline);
      chk("err", err_unexp_resp, err_m);
      chk("state", dbg_state, exp_state);
      if (m0_resp_valid) begin resp_cnt[0]++; last_rline[0] = m0_resp_rline; end
      if (m1_resp_valid) begin resp_cnt[1]++; last_rline[1] = m1_resp_rline; end
      if (l2_resp_valid && !(busy && sent)) err_m = 1;
      if (!busy) begin
        if (m0_req_valid || m1_req_valid) begin
          busy = 1; sent = 0; owner_m = (p == 1); pref = (p == 0);
          rw_m    = (p == 1) ? m1_req_rw    : m0_req_rw;
          addr_m  = (p == 1) ? m1_req_addr  : m0_req_addr;
          wline_m = (p == 1) ? m1_req_wline : m0_req_wline;
        end
      end else if (!sent) begin
        if (l2_req_ready) begin
          acc_q.push_back(addr_m);
          sent = 1;
          if (rw_m) busy = 0;
        end
      end else if (l2_resp_valid) begin
        busy = 0;
      end
    end
  end

  // ---------------- L2 responder ----------------
  bit                rand_l2 = 0;
  bit                spur_req = 0;
  int                stall_cfg = 0, stall_left = 0, resp_delay = 3, cd = 0;
  logic [LINE_W-1:0] resp_line = '0;

  initial begin
    l2_req_ready  = 1'b1;
    l2_resp_valid = 1'b0;
    l2_resp_rline = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cd = 0;
      end else if (l2_req_valid && l2_req_ready) begin
        if (!l2_req_rw) cd = rand_l2 ? $urandom_range(1, 4) : resp_delay;
        stall_left = stall_cfg;
      end else if (l2_req_valid && stall_left > 0) begin
        stall_left--;
      end
      @(posedge clk); #1;
      l2_resp_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          l2_resp_valid = 1'b1;
          l2_resp_rline = rand_l2 ? rand_line() : resp_line;
        end
      end
      if (spur_req) begin
        l2_resp_valid = 1'b1;
        spur_req = 0;
      end
      l2_req_ready = rand_l2 ? ($urandom_range(0, 2) != 0) : (stall_left == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_stall(input int n);
    stall_cfg = n;
    stall_left = n;
  endtask

  task automatic drive_req(input int port, input logic rw, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] wl);
    int n = 0;
    if (port == 0) begin
      m0_req_valid = 1; m0_req_rw = rw; m0_req_addr = addr; m0_req_wline = wl;
    end else begin
      m1_req_valid = 1; m1_req_rw = rw; m1_req_addr = addr; m1_req_wline = wl;
    end
    forever begin
      @(negedge clk);
      if ((port == 0) ? m0_req_ready : m1_req_ready) break;
      n++;
      if (n > 400) begin
        chk("req_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    if (port == 0) m0_req_valid = 0; else m1_req_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy || cd != 0 || l2_resp_valid) begin
      tick();
      n++;
      if (n > 300) begin
        chk("idle_timeout", 1, 0);
        break;
      end
    end
    tick();
  endtask

  task automatic do_reset();
    m0_req_valid = 0; m1_req_valid = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic clear_obs();
    acc_q.delete();
    resp_cnt[0] = 0; resp_cnt[1] = 0;
  endtask

  task automatic rand_port(input int port, input int n_tx);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < n_tx; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = $urandom;
      a[5:0] = '0;
      drive_req(port, 1'($urandom_range(0, 1)), a, rand_line());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m0_req_valid = 0; m0_req_rw = 0; m0_req_addr = '0; m0_req_wline = '0;
    m1_req_valid = 0; m1_req_rw = 0; m1_req_addr = '0; m1_req_wline = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick();

    // single read on port 0
    clear_obs();
    resp_line = {32{8'hA5}};
    drive_req(0, 1'b0, 32'h0000_1040, '0);
    chk("t1_addr", l2_req_addr, 32'h0000_1040);
    chk("t1_rw", l2_req_rw, 0);
    wait_idle();
    chk("t1_m0_pulses", resp_cnt[0], 1);
    chk("t1_m1_pulses", resp_cnt[1], 0);
    chk("t1_rline", last_rline[0], {32{8'hA5}});

    // simultaneous reads after reset
    do_reset();
    clear_obs();
    resp_line = {32{8'h3C}};
    fork
      drive_req(0, 1'b0, 32'h100, '0);
      drive_req(1, 1'b0, 32'h200, '0);
    join
    wait_idle();
    chk("t2_count", acc_q.size(), 2);
    chk("t2_first", acc_q[0], 32'h100);
    chk("t2_second", acc_q[1], 32'h200);
    chk("t2_m0_pulses", resp_cnt[0], 1);
    chk("t2_m1_pulses", resp_cnt[1], 1);

    // writeback then refill on port 1 with L2 stalled 5 cycles each
    clear_obs();
    set_stall(5);
    drive_req(1, 1'b1, 32'h300, {16{16'h1234}});
    drive_req(1, 1'b0, 32'h400, '0);
    wait_idle();
    chk("t3_first", acc_q[0], 32'h300);
    chk("t3_second", acc_q[1], 32'h400);
    chk("t3_m1_pulses", resp_cnt[1], 1);
    chk("t3_m0_pulses", resp_cnt[0], 0);

    // back-pressure on m0 read while m1 competes
    clear_obs();
    set_stall(4);
    fork
      drive_req(0, 1'b0, 32'h500, '0);
      begin tick(); tick(); drive_req(1, 1'b0, 32'h600, '0); end
    join
    wait_idle();
    set_stall(0);
    chk("t4_first", acc_q[0], 32'h500);
    chk("t4_second", acc_q[1], 32'h600);

    // spurious response in idle
    clear_obs();
    spur_req = 1;
    repeat (3) tick();
    chk("t5_err_set", err_unexp_resp, 1);
    chk("t5_no_resp", resp_cnt[0] + resp_cnt[1], 0);
    repeat (3) tick();
    chk("t5_err_sticky", err_unexp_resp, 1);
    do_reset();
    chk("t5_err_cleared", err_unexp_resp, 0);

    // reset while a read is outstanding
    resp_delay = 10;
    drive_req(0, 1'b0, 32'h700, '0);
    tick(); tick();
    chk("t6_in_wait", dbg_state, 2);
    rst_n = 0;
    #1;
    chk("t6_async_state", dbg_state, 0);
    chk("t6_async_l2_valid", l2_req_valid, 0);
    tick();
    rst_n = 1;
    tick();
    resp_delay = 3;
    repeat (12) tick();
    chk("t6_no_late_resp", err_unexp_resp, 0);

    // writeback vs refill arbitration, rr_ptr=1 then rr_ptr=0
    do_reset();
    drive_req(0, 1'b0, 32'h800, '0);
    wait_idle();
    clear_obs();
    fork
      drive_req(0, 1'b0, 32'h900, '0);
      drive_req(1, 1'b1, 32'hA00, rand_line());
    join
    wait_idle();
    chk("t7_rr1_first", acc_q[0], 32'hA00);
    do_reset();
    clear_obs();
    fork
      drive_req(0, 1'b0, 32'h900, '0);
      drive_req(1, 1'b1, 32'hA00, rand_line());
    join
    wait_idle();
`ifdef L2ARB_WB_PRIO_EN
    chk("t7_rr0_first", acc_q[0], 32'hA00);
`else
    chk("t7_rr0_first", acc_q[0], 32'h900);
`endif

    // random traffic on both ports against a randomly stalling L2
    rand_l2 = 1;
    fork
      rand_port(0, 120);
      rand_port(1, 120);
    join
    wait_idle();
    rand_l2 = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
